// File: rtl/rv_iommu_ls_pkg.sv
// Shared types for the IOMMU walker load/store initiator.
package rv_iommu_ls_pkg;

  // Field widths of the default initiator instance; ls_req_t is sized from these.
  localparam int LS_ADDR_W = 46;
  localparam int LS_SIZE_W = 7;
  localparam int LS_TAG_W  = 2;

  // Op encodings must stay aligned with the consts.vh users.
  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_AMO   = 2'd2
  } ls_op_e;

  typedef enum logic [1:0] {
    IS_IDLE = 2'd0,
    IS_REQ  = 2'd1,
    IS_REL  = 2'd2
  } issue_state_e;

  typedef enum logic {
    RS_IDLE = 1'b0,
    RS_ACK  = 1'b1
  } ret_state_e;

  typedef struct packed {
    logic [LS_ADDR_W-1:0] addr;
    ls_op_e               op;
    logic [LS_SIZE_W-1:0] size;
    logic [LS_TAG_W-1:0]  tag;
  } ls_req_t;

  // Ops that expect a data return on the w_ld_* channel.
  function automatic logic is_data_op(input logic [1:0] op);
    return (op == OP_LOAD) || (op == OP_AMO);
  endfunction

endpackage

// File: rtl/rv_iommu_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rv_iommu_rr_arb #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Scan from the far end so the candidate closest to ptr is the last one written.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/rv_iommu_ls_init.sv
// Walker-side initiator of the IOMMU load/store port. Arbitrates MAX_PW walk
// clients, issues one tagged request at a time over the 4-phase w_ls_* handshake
// and routes w_ld_* returns back to the owning client by tag.
//
//  state    | meaning
//  IS_IDLE  | no request on the port; pick next eligible client
//  IS_REQ   | request irdy high, waiting for responder trdy
//  IS_REL   | irdy dropped, waiting for trdy release; stores complete here
//  RS_IDLE  | no return in progress
//  RS_ACK   | return captured, trdy high, waiting for irdy release
module rv_iommu_ls_init
  import rv_iommu_ls_pkg::*;
#(
  parameter  int MAX_PW = 4,
  parameter  int ADDR_W = LS_ADDR_W,
  parameter  int DATA_W = 512,
  localparam int TW     = (MAX_PW > 1) ? $clog2(MAX_PW) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [MAX_PW-1:0]      cl_req_irdy_i,
  output logic [MAX_PW-1:0]      cl_req_trdy_o,
  input  logic [MAX_PW*ADDR_W-1:0] cl_addr_i,
  input  logic [MAX_PW*2-1:0]    cl_op_i,
  input  logic [MAX_PW*7-1:0]    cl_size_i,
  output logic [MAX_PW-1:0]      cl_ld_valid_o,
  output logic [MAX_PW-1:0]      cl_st_done_o,
  output logic [DATA_W-1:0]      cl_ld_data_o,
  output logic                   cl_ld_acc_fault_o,
  output logic                   cl_ld_poison_o,
  output logic [ADDR_W-1:0]      w_ls_addr_o,
  output logic [1:0]             w_ls_op_o,
  output logic [6:0]             w_ls_size_o,
  output logic [TW-1:0]          w_ls_tag_o,
  output logic                   w_ls_req_irdy_o,
  input  logic                   w_ls_req_trdy_i,
  input  logic [DATA_W-1:0]      w_ld_data_i,
  input  logic                   w_ld_acc_fault_i,
  input  logic                   w_ld_poison_i,
  input  logic [TW-1:0]          w_ld_tag_i,
  input  logic                   w_ld_data_irdy_i,
  output logic                   w_ld_data_trdy_o,
  output logic                   err_unexp_tag_o
);

  issue_state_e is_q, is_n;
  ret_state_e   rs_q, rs_n;

  logic [MAX_PW-1:0] ob_q, ob_set, ob_clr_st, ob_clr_ld;
  logic [1:0]        op_q [MAX_PW];
  logic [TW-1:0]     rr_q, rr_n;

  ls_req_t           req_q, req_n;
  logic              irdy_q, irdy_n;
  logic [MAX_PW-1:0] trdy_q, trdy_n;
  logic [MAX_PW-1:0] st_done_q, st_done_n;

  logic              dtrdy_q, dtrdy_n;
  logic [DATA_W-1:0] cap_data_q, cap_data_n;
  logic              cap_fault_q, cap_fault_n;
  logic              cap_poison_q, cap_poison_n;
  logic [TW-1:0]     cap_tag_q, cap_tag_n;
  logic [MAX_PW-1:0] ld_valid_q, ld_valid_n;
  logic [DATA_W-1:0] ld_data_q, ld_data_n;
  logic              ld_fault_q, ld_fault_n;
  logic              ld_poison_q, ld_poison_n;
  logic              err_q, err_n;

  logic [MAX_PW-1:0] eligible, gnt;
  logic [TW-1:0]     gidx;

  // Registered ob keeps a client out of arbitration until the cycle after it completes.
  assign eligible = cl_req_irdy_i & ~ob_q;

  rv_iommu_rr_arb #(.N(MAX_PW)) u_arb (
    .req (eligible),
    .ptr (rr_q),
    .gnt (gnt),
    .idx (gidx)
  );

  // Issue FSM next-state and registered-output values.
  always_comb begin
    is_n      = is_q;
    req_n     = req_q;
    irdy_n    = irdy_q;
    trdy_n    = '0;
    st_done_n = '0;
    rr_n      = rr_q;
    ob_set    = '0;
    ob_clr_st = '0;
    unique case (is_q)
      IS_IDLE: begin
        if (|eligible) begin
          trdy_n     = gnt;
          ob_set     = gnt;
          irdy_n     = 1'b1;
          req_n.addr = cl_addr_i[int'(gidx)*ADDR_W +: ADDR_W];
          req_n.op   = ls_op_e'(cl_op_i[int'(gidx)*2 +: 2]);
          req_n.size = cl_size_i[int'(gidx)*7 +: 7];
          req_n.tag  = gidx;
          rr_n       = (int'(gidx) == MAX_PW - 1) ? '0 : gidx + 1'b1;
          is_n       = IS_REQ;
        end
      end
      IS_REQ: begin
        if (w_ls_req_trdy_i) begin
          irdy_n = 1'b0;
          is_n   = IS_REL;
        end
      end
      IS_REL: begin
        if (!w_ls_req_trdy_i) begin
          if (req_q.op == OP_STORE) begin
            st_done_n[req_q.tag] = 1'b1;
            ob_clr_st[req_q.tag] = 1'b1;
          end
          is_n = IS_IDLE;
        end
      end
      default: is_n = IS_IDLE;
    endcase
  end

  // Issue FSM state and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_q      <= IS_IDLE;
      req_q     <= '0;
      irdy_q    <= 1'b0;
      trdy_q    <= '0;
      st_done_q <= '0;
      rr_q      <= '0;
    end else begin
      is_q      <= is_n;
      req_q     <= req_n;
      irdy_q    <= irdy_n;
      trdy_q    <= trdy_n;
      st_done_q <= st_done_n;
      rr_q      <= rr_n;
    end
  end

  // Return FSM next-state; a return is only delivered if its tag awaits data.
  always_comb begin
    rs_n         = rs_q;
    dtrdy_n      = dtrdy_q;
    cap_data_n   = cap_data_q;
    cap_fault_n  = cap_fault_q;
    cap_poison_n = cap_poison_q;
    cap_tag_n    = cap_tag_q;
    ld_valid_n   = '0;
    ld_data_n    = ld_data_q;
    ld_fault_n   = ld_fault_q;
    ld_poison_n  = ld_poison_q;
    err_n        = err_q;
    ob_clr_ld    = '0;
    unique case (rs_q)
      RS_IDLE: begin
        if (w_ld_data_irdy_i) begin
          cap_data_n   = w_ld_data_i;
          cap_fault_n  = w_ld_acc_fault_i;
          cap_poison_n = w_ld_poison_i;
          cap_tag_n    = w_ld_tag_i;
          dtrdy_n      = 1'b1;
          rs_n         = RS_ACK;
        end
      end
      RS_ACK: begin
        if (!w_ld_data_irdy_i) begin
          dtrdy_n = 1'b0;
          if (ob_q[cap_tag_q] && is_data_op(op_q[cap_tag_q])) begin
            ld_valid_n[cap_tag_q] = 1'b1;
            ob_clr_ld[cap_tag_q]  = 1'b1;
            ld_data_n             = cap_data_q;
            ld_fault_n            = cap_fault_q;
            ld_poison_n           = cap_poison_q;
          end else begin
            err_n = 1'b1;
          end
          rs_n = RS_IDLE;
        end
      end
      default: rs_n = RS_IDLE;
    endcase
  end

  // Return FSM state, capture and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_q         <= RS_IDLE;
      dtrdy_q      <= 1'b0;
      cap_data_q   <= '0;
      cap_fault_q  <= 1'b0;
      cap_poison_q <= 1'b0;
      cap_tag_q    <= '0;
      ld_valid_q   <= '0;
      ld_data_q    <= '0;
      ld_fault_q   <= 1'b0;
      ld_poison_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rs_q         <= rs_n;
      dtrdy_q      <= dtrdy_n;
      cap_data_q   <= cap_data_n;
      cap_fault_q  <= cap_fault_n;
      cap_poison_q <= cap_poison_n;
      cap_tag_q    <= cap_tag_n;
      ld_valid_q   <= ld_valid_n;
      ld_data_q    <= ld_data_n;
      ld_fault_q   <= ld_fault_n;
      ld_poison_q  <= ld_poison_n;
      err_q        <= err_n;
    end
  end

  // Outstanding bitmap and per-client op; set and clear never target the same client.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ob_q <= '0;
      for (int i = 0; i < MAX_PW; i++) op_q[i] <= '0;
    end else begin
      ob_q <= (ob_q & ~(ob_clr_st | ob_clr_ld)) | ob_set;
      for (int i = 0; i < MAX_PW; i++) begin
        if (ob_set[i]) op_q[i] <= cl_op_i[i*2 +: 2];
      end
    end
  end

  assign cl_req_trdy_o     = trdy_q;
  assign cl_st_done_o      = st_done_q;
  assign cl_ld_valid_o     = ld_valid_q;
  assign cl_ld_data_o      = ld_data_q;
  assign cl_ld_acc_fault_o = ld_fault_q;
  assign cl_ld_poison_o    = ld_poison_q;
  assign w_ls_addr_o       = req_q.addr;
  assign w_ls_op_o         = req_q.op;
  assign w_ls_size_o       = req_q.size;
  assign w_ls_tag_o        = req_q.tag;
  assign w_ls_req_irdy_o   = irdy_q;
  assign w_ld_data_trdy_o  = dtrdy_q;
  assign err_unexp_tag_o   = err_q;

endmodule

// File: tb/tb_rv_iommu_ls_init.sv
// Directed bench for rv_iommu_ls_init; bench plays both clients and responder.
module tb_rv_iommu_ls_init;

  localparam int NP = 4;
  localparam int AW = 46;
  localparam int DW = 512;
  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] STORE = 2'd1;
  localparam logic [1:0] AMO   = 2'd2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP-1:0]   cl_req_irdy_i = '0;
  logic [NP-1:0]   cl_req_trdy_o;
  logic [NP*AW-1:0] cl_addr_i = '0;
  logic [NP*2-1:0] cl_op_i = '0;
  logic [NP*7-1:0] cl_size_i = '0;
  logic [NP-1:0]   cl_ld_valid_o;
  logic [NP-1:0]   cl_st_done_o;
  logic [DW-1:0]   cl_ld_data_o;
  logic            cl_ld_acc_fault_o;
  logic            cl_ld_poison_o;
  logic [AW-1:0]   w_ls_addr_o;
  logic [1:0]      w_ls_op_o;
  logic [6:0]      w_ls_size_o;
  logic [1:0]      w_ls_tag_o;
  logic            w_ls_req_irdy_o;
  logic            w_ls_req_trdy_i = 1'b0;
  logic [DW-1:0]   w_ld_data_i = '0;
  logic            w_ld_acc_fault_i = 1'b0;
  logic            w_ld_poison_i = 1'b0;
  logic [1:0]      w_ld_tag_i = '0;
  logic            w_ld_data_irdy_i = 1'b0;
  logic            w_ld_data_trdy_o;
  logic            err_unexp_tag_o;

  int n_cmp = 0;
  int n_bad = 0;

  rv_iommu_ls_init #(.MAX_PW(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cl_req_irdy_i     (cl_req_irdy_i),
    .cl_req_trdy_o     (cl_req_trdy_o),
    .cl_addr_i         (cl_addr_i),
    .cl_op_i           (cl_op_i),
    .cl_size_i         (cl_size_i),
    .cl_ld_valid_o     (cl_ld_valid_o),
    .cl_st_done_o      (cl_st_done_o),
    .cl_ld_data_o      (cl_ld_data_o),
    .cl_ld_acc_fault_o (cl_ld_acc_fault_o),
    .cl_ld_poison_o    (cl_ld_poison_o),
    .w_ls_addr_o       (w_ls_addr_o),
    .w_ls_op_o         (w_ls_op_o),
    .w_ls_size_o       (w_ls_size_o),
    .w_ls_tag_o        (w_ls_tag_o),
    .w_ls_req_irdy_o   (w_ls_req_irdy_o),
    .w_ls_req_trdy_i   (w_ls_req_trdy_i),
    .w_ld_data_i       (w_ld_data_i),
    .w_ld_acc_fault_i  (w_ld_acc_fault_i),
    .w_ld_poison_i     (w_ld_poison_i),
    .w_ld_tag_i        (w_ld_tag_i),
    .w_ld_data_irdy_i  (w_ld_data_irdy_i),
    .w_ld_data_trdy_o  (w_ld_data_trdy_o),
    .err_unexp_tag_o   (err_unexp_tag_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int i, input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [6:0] size);
    cl_addr_i[i*AW +: AW] = addr;
    cl_op_i[i*2 +: 2]     = op;
    cl_size_i[i*7 +: 7]   = size;
  endtask

  // Wait for the next issue, check it, then run the responder side of the 4-phase.
  task automatic serve_issue(input int tag, input logic [1:0] op, input logic [AW-1:0] addr,
                             input logic [6:0] size);
    int n;
    logic [3:0] onehot;
    n = 0;
    onehot = 4'b0001 << tag;
    while (!w_ls_req_irdy_o && n < 20) begin
      tick();
      n++;
    end
    check_eq("issue_seen", 64'(w_ls_req_irdy_o), 64'd1);
    check_eq("issue_tag", 64'(w_ls_tag_o), 64'(tag));
    check_eq("issue_trdy_pulse", 64'(cl_req_trdy_o), 64'(onehot));
    check_eq("issue_addr", 64'(w_ls_addr_o), 64'(addr));
    check_eq("issue_op", 64'(w_ls_op_o), 64'(op));
    check_eq("issue_size", 64'(w_ls_size_o), 64'(size));
    cl_req_irdy_i[tag] = 1'b0;
    tick();
    check_eq("trdy_one_cycle", 64'(cl_req_trdy_o), 64'd0);
    check_eq("irdy_held", 64'(w_ls_req_irdy_o), 64'd1);
    w_ls_req_trdy_i = 1'b1;
    tick();
    check_eq("irdy_dropped", 64'(w_ls_req_irdy_o), 64'd0);
    w_ls_req_trdy_i = 1'b0;
    tick();
    check_eq("st_done", 64'(cl_st_done_o), (op == STORE) ? 64'(onehot) : 64'd0);
  endtask

  // Drive one data return through the 4-phase and check the client-side result.
  task automatic ret_data(input int tag, input logic [63:0] d, input logic f, input logic p,
                          input logic [3:0] exp_v, input logic exp_err);
    w_ld_tag_i       = 2'(tag);
    w_ld_data_i      = {448'd0, d};
    w_ld_acc_fault_i = f;
    w_ld_poison_i    = p;
    w_ld_data_irdy_i = 1'b1;
    tick();
    check_eq("ret_trdy_high", 64'(w_ld_data_trdy_o), 64'd1);
    check_eq("ret_no_early_valid", 64'(cl_ld_valid_o), 64'd0);
    w_ld_data_irdy_i = 1'b0;
    tick();
    check_eq("ret_trdy_low", 64'(w_ld_data_trdy_o), 64'd0);
    check_eq("ret_valid", 64'(cl_ld_valid_o), 64'(exp_v));
    check_eq("ret_err", 64'(err_unexp_tag_o), 64'(exp_err));
    if (exp_v != 4'd0) begin
      check_eq("ret_data", cl_ld_data_o[63:0], d);
      check_eq("ret_fault", 64'(cl_ld_acc_fault_o), 64'(f));
      check_eq("ret_poison", 64'(cl_ld_poison_o), 64'(p));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cl_req_irdy_i = '0;
    w_ls_req_trdy_i = 1'b0;
    w_ld_data_irdy_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values
    do_reset();
    check_eq("rst_irdy", 64'(w_ls_req_irdy_o), 64'd0);
    check_eq("rst_trdy", 64'(cl_req_trdy_o), 64'd0);
    check_eq("rst_dtrdy", 64'(w_ld_data_trdy_o), 64'd0);
    check_eq("rst_err", 64'(err_unexp_tag_o), 64'd0);
    check_eq("rst_valid", 64'(cl_ld_valid_o), 64'd0);

    // Single load from client 0
    set_client(0, LOAD, 46'h1000, 7'd8);
    cl_req_irdy_i = 4'b0001;
    serve_issue(0, LOAD, 46'h1000, 7'd8);
    ret_data(0, 64'h2001, 1'b0, 1'b0, 4'b0001, 1'b0);
    tick();
    check_eq("valid_one_cycle", 64'(cl_ld_valid_o), 64'd0);
    check_eq("data_holds", cl_ld_data_o[63:0], 64'h2001);
    check_eq("data_upper_zero", 64'(|cl_ld_data_o[DW-1:64]), 64'd0);

    // All four at once from a fresh pointer
    do_reset();
    set_client(0, LOAD,  46'h100, 7'd1);
    set_client(1, STORE, 46'h200, 7'd2);
    set_client(2, AMO,   46'h300, 7'd3);
    set_client(3, STORE, 46'h400, 7'd4);
    cl_req_irdy_i = 4'b1111;
    serve_issue(0, LOAD,  46'h100, 7'd1);
    serve_issue(1, STORE, 46'h200, 7'd2);
    serve_issue(2, AMO,   46'h300, 7'd3);
    serve_issue(3, STORE, 46'h400, 7'd4);

    // Re-request with 0 and 2 still outstanding: only 1 then 3 are eligible
    set_client(1, STORE, 46'h210, 7'd5);
    set_client(3, STORE, 46'h410, 7'd6);
    cl_req_irdy_i = 4'b1111;
    serve_issue(1, STORE, 46'h210, 7'd5);
    serve_issue(3, STORE, 46'h410, 7'd6);
    cl_req_irdy_i = 4'b0000;
    tick();
    check_eq("blocked_no_issue", 64'(w_ls_req_irdy_o), 64'd0);

    ret_data(2, 64'h2222, 1'b1, 1'b0, 4'b0100, 1'b0);
    ret_data(0, 64'h3333, 1'b0, 1'b1, 4'b0001, 1'b0);

    // Return for a tag that awaits nothing
    ret_data(3, 64'hdead, 1'b0, 1'b0, 4'b0000, 1'b1);
    check_eq("err_drop_keeps_data", cl_ld_data_o[63:0], 64'h3333);
    tick();
    check_eq("err_sticky", 64'(err_unexp_tag_o), 64'd1);

    // Lone store from client 2
    set_client(2, STORE, 46'h3_0000_0040, 7'd64);
    cl_req_irdy_i = 4'b0100;
    serve_issue(2, STORE, 46'h3_0000_0040, 7'd64);
    tick();
    check_eq("st_done_one_cycle", 64'(cl_st_done_o), 64'd0);
    check_eq("err_still_sticky", 64'(err_unexp_tag_o), 64'd1);

    // Store completion and load return in the same cycle
    set_client(0, LOAD, 46'h5000, 7'd8);
    cl_req_irdy_i = 4'b0001;
    serve_issue(0, LOAD, 46'h5000, 7'd8);
    set_client(1, STORE, 46'h6000, 7'd8);
    cl_req_irdy_i = 4'b0010;
    tick();
    check_eq("sim_issue", 64'(w_ls_req_irdy_o), 64'd1);
    check_eq("sim_tag", 64'(w_ls_tag_o), 64'd1);
    cl_req_irdy_i = 4'b0000;
    w_ls_req_trdy_i = 1'b1;
    tick();
    w_ld_tag_i = 2'd0;
    w_ld_data_i = {448'd0, 64'h4444};
    w_ld_acc_fault_i = 1'b0;
    w_ld_poison_i = 1'b0;
    w_ld_data_irdy_i = 1'b1;
    tick();
    check_eq("sim_dtrdy", 64'(w_ld_data_trdy_o), 64'd1);
    check_eq("sim_no_early_done", 64'(cl_st_done_o), 64'd0);
    w_ls_req_trdy_i = 1'b0;
    w_ld_data_irdy_i = 1'b0;
    tick();
    check_eq("sim_st_done", 64'(cl_st_done_o), 64'b0010);
    check_eq("sim_ld_valid", 64'(cl_ld_valid_o), 64'b0001);
    check_eq("sim_ld_data", cl_ld_data_o[63:0], 64'h4444);

    // Reset while a request is pending on the port
    set_client(3, LOAD, 46'h7000, 7'd16);
    cl_req_irdy_i = 4'b1000;
    tick();
    check_eq("pre_rst_irdy", 64'(w_ls_req_irdy_o), 64'd1);
    check_eq("pre_rst_tag", 64'(w_ls_tag_o), 64'd3);
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_irdy", 64'(w_ls_req_irdy_o), 64'd0);
    check_eq("mid_rst_tag", 64'(w_ls_tag_o), 64'd0);
    check_eq("mid_rst_addr", 64'(w_ls_addr_o), 64'd0);
    check_eq("mid_rst_trdy", 64'(cl_req_trdy_o), 64'd0);
    check_eq("mid_rst_err", 64'(err_unexp_tag_o), 64'd0);
    check_eq("mid_rst_data", cl_ld_data_o[63:0], 64'd0);
    check_eq("mid_rst_done", 64'(cl_st_done_o), 64'd0);
    rst_n = 1'b1;
    serve_issue(3, LOAD, 46'h7000, 7'd16);
    ret_data(3, 64'h7777, 1'b0, 1'b0, 4'b1000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
